// File: rtl/apb_port_arbiter.sv
// Round-robin arbiter that funnels several request ports onto one APB master,
// with clock-enable gating and an optional ACCESS-phase timeout.
module apb_port_arbiter #(
    parameter int NumPorts      = 2,
    parameter int TimeoutCycles = 16
) (
    input  logic                     a_clk,
    input  logic                     a_reset_n,
    input  logic [NumPorts-1:0]      req_valid,
    input  logic [NumPorts-1:0][31:0] req_addr,
    input  logic [NumPorts-1:0]      req_write,
    input  logic [NumPorts-1:0][31:0] req_wdata,
    output logic [NumPorts-1:0]      done,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_slverr,
    input  logic                     p_clk_en,
    output logic [31:0]              p_addr,
    output logic                     p_sel,
    output logic                     p_enable,
    output logic                     p_write,
    output logic [31:0]              p_wdata,
    input  logic [31:0]              p_rdata,
    input  logic                     p_ready,
    input  logic                     p_slverr
);

    localparam int GW = $clog2(NumPorts);
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner;
    logic [TW-1:0] timeout_count;
    logic          timeout_hit;
    logic          complete;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int            idx_int;
        logic [GW-1:0] idx;
        logic          found;
        winner  = grant;
        found   = 1'b0;
        idx_int = 0;
        idx     = '0;
        for (int i = 1; i <= NumPorts; i++) begin
            idx_int = int'(last_grant) + i;
            if (idx_int >= NumPorts) begin
                idx_int = idx_int - NumPorts;
            end
            idx = GW'(idx_int);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    generate
        if (TimeoutCycles > 0) begin : g_timeout
            assign timeout_hit = !p_ready && (timeout_count == TW'(TimeoutCycles - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign complete = (state == ACCESS) && p_clk_en && (p_ready || timeout_hit);

    always_ff @(posedge a_clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= GW'(NumPorts - 1);
            timeout_count <= '0;
        end else if (p_clk_en) begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant      <= winner;
                        last_grant <= winner;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    timeout_count <= '0;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    if (complete) begin
                        state <= IDLE;
                    end else begin
                        timeout_count <= timeout_count + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A timeout completion reports an error with zeroed read data.
    always_comb begin
        done       = '0;
        rsp_rdata  = '0;
        rsp_slverr = 1'b0;
        if (complete) begin
            done[grant] = 1'b1;
            if (p_ready) begin
                rsp_rdata  = p_rdata;
                rsp_slverr = p_slverr;
            end else begin
                rsp_slverr = 1'b1;
            end
        end
    end

    assign p_sel    = (state != IDLE);
    assign p_enable = (state == ACCESS);
    assign p_addr   = req_addr[grant];
    assign p_write  = req_write[grant];
    assign p_wdata  = req_wdata[grant];

endmodule

// File: tb/tb_apb_port_arbiter.sv
// Directed bench for apb_port_arbiter: reset, fairness, clock enable,
// timeout, slave error and reset during ACCESS.
module tb_apb_port_arbiter;

    logic              a_clk;
    logic              a_reset_n;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        req_write;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        done;
    logic [31:0]       rsp_rdata;
    logic              rsp_slverr;
    logic              p_clk_en;
    logic [31:0]       p_addr;
    logic              p_sel;
    logic              p_enable;
    logic              p_write;
    logic [31:0]       p_wdata;
    logic [31:0]       p_rdata;
    logic              p_ready;
    logic              p_slverr;

    int checks;
    int errors;

    logic [8:0] exp_sel_v;
    logic [8:0] exp_pen_v;
    logic [8:0] exp_done_v;

    apb_port_arbiter #(
        .NumPorts      (2),
        .TimeoutCycles (4)
    ) dut (
        .a_clk      (a_clk),
        .a_reset_n  (a_reset_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .done       (done),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .p_clk_en   (p_clk_en),
        .p_addr     (p_addr),
        .p_sel      (p_sel),
        .p_enable   (p_enable),
        .p_write    (p_write),
        .p_wdata    (p_wdata),
        .p_rdata    (p_rdata),
        .p_ready    (p_ready),
        .p_slverr   (p_slverr)
    );

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        a_reset_n  = 1'b0;
        p_clk_en   = 1'b1;
        req_valid  = 2'b00;
        req_addr[0] = 32'h0000_00A0;
        req_addr[1] = 32'h0000_00B0;
        req_write  = 2'b00;
        req_wdata  = '0;
        p_rdata    = 32'h0;
        p_ready    = 1'b0;
        p_slverr   = 1'b0;

        // Reset state: idle bus, port 0 selected by the address mux.
        repeat (2) @(negedge a_clk);
        #1;
        check_output("rst_psel", 32'(p_sel), 32'd0);
        check_output("rst_penable", 32'(p_enable), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_paddr", p_addr, 32'h0000_00A0);
        check_output("rst_rdata", rsp_rdata, 32'h0);

        // Fairness: both ports request continuously.
        a_reset_n   = 1'b1;
        req_addr[0] = 32'h0000_1000;
        req_addr[1] = 32'h0000_2000;
        req_valid   = 2'b11;
        p_ready     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge a_clk); #1;
            check_output("fair_setup_addr", p_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
            check_output("fair_setup_penable", 32'(p_enable), 32'd0);
            @(negedge a_clk); #1;
            check_output("fair_done", 32'(done), (i % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge a_clk); #1;
            check_output("fair_idle_done", 32'(done), 32'd0);
        end

        // Single read from port 0.
        req_valid    = 2'b01;
        req_addr[0]  = 32'h0000_0100;
        req_write[0] = 1'b0;
        p_rdata      = 32'hDEAD_BEEF;
        p_ready      = 1'b1;
        @(negedge a_clk); #1;
        check_output("rd_setup_psel", 32'(p_sel), 32'd1);
        check_output("rd_setup_penable", 32'(p_enable), 32'd0);
        check_output("rd_setup_addr", p_addr, 32'h0000_0100);
        check_output("rd_setup_write", 32'(p_write), 32'd0);
        check_output("rd_setup_done", 32'(done), 32'd0);
        @(negedge a_clk); #1;
        check_output("rd_access_penable", 32'(p_enable), 32'd1);
        check_output("rd_done", 32'(done), 32'd1);
        check_output("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check_output("rd_slverr", 32'(rsp_slverr), 32'd0);
        req_valid = 2'b00;
        @(negedge a_clk); #1;
        check_output("rd_idle_psel", 32'(p_sel), 32'd0);
        check_output("rd_idle_done", 32'(done), 32'd0);
        check_output("rd_idle_rdata", rsp_rdata, 32'h0);

        // Clock enable high every third cycle, single write from port 0.
        req_valid    = 2'b01;
        req_addr[0]  = 32'h0000_0020;
        req_write[0] = 1'b1;
        req_wdata[0] = 32'h5A5A_5A5A;
        exp_sel_v    = 9'b111111000;
        exp_pen_v    = 9'b111000000;
        exp_done_v   = 9'b100000000;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge a_clk);
            p_clk_en = (c % 3 == 2);
            #1;
            check_output("ce_psel", 32'(p_sel), 32'(exp_sel_v[c]));
            check_output("ce_penable", 32'(p_enable), 32'(exp_pen_v[c]));
            check_output("ce_done", 32'(done), 32'(exp_done_v[c]));
            if (c == 3) begin
                check_output("ce_wdata", p_wdata, 32'h5A5A_5A5A);
                check_output("ce_write", 32'(p_write), 32'd1);
                check_output("ce_addr", p_addr, 32'h0000_0020);
            end
            if (c == 8) req_valid = 2'b00;
        end
        @(negedge a_clk);
        p_clk_en = 1'b1;
        #1;
        check_output("ce_idle_psel", 32'(p_sel), 32'd0);

        // Timeout on port 1 with p_ready held low.
        req_valid    = 2'b10;
        req_addr[1]  = 32'h0000_0300;
        req_write[1] = 1'b0;
        p_ready      = 1'b0;
        p_rdata      = 32'hFFFF_FFFF;
        @(negedge a_clk); #1;
        check_output("to_setup_addr", p_addr, 32'h0000_0300);
        for (int k = 1; k <= 4; k++) begin
            @(negedge a_clk); #1;
            check_output("to_done", 32'(done), (k == 4) ? 32'd2 : 32'd0);
            if (k == 4) begin
                check_output("to_slverr", 32'(rsp_slverr), 32'd1);
                check_output("to_rdata", rsp_rdata, 32'h0);
                req_valid = 2'b00;
            end
        end
        @(negedge a_clk); #1;
        check_output("to_idle_psel", 32'(p_sel), 32'd0);
        check_output("to_idle_done", 32'(done), 32'd0);
        req_valid    = 2'b01;
        req_addr[0]  = 32'h0000_0400;
        req_write[0] = 1'b0;
        p_ready      = 1'b1;
        p_rdata      = 32'h1234_5678;
        @(negedge a_clk);
        @(negedge a_clk); #1;
        check_output("post_to_done", 32'(done), 32'd1);
        check_output("post_to_rdata", rsp_rdata, 32'h1234_5678);
        check_output("post_to_slverr", 32'(rsp_slverr), 32'd0);
        req_valid = 2'b00;

        // Slave error with normal completion.
        @(negedge a_clk); #1;
        req_valid = 2'b01;
        p_slverr  = 1'b1;
        p_rdata   = 32'hCAFE_F00D;
        @(negedge a_clk);
        @(negedge a_clk); #1;
        check_output("se_done", 32'(done), 32'd1);
        check_output("se_slverr", 32'(rsp_slverr), 32'd1);
        check_output("se_rdata", rsp_rdata, 32'hCAFE_F00D);
        req_valid = 2'b00;
        @(negedge a_clk); #1;
        check_output("se_idle_slverr", 32'(rsp_slverr), 32'd0);
        check_output("se_idle_done", 32'(done), 32'd0);
        p_slverr = 1'b0;

        // Reset asserted mid-ACCESS on a port 0 transfer.
        req_valid   = 2'b01;
        req_addr[0] = 32'h0000_0500;
        req_addr[1] = 32'h0000_0600;
        p_ready     = 1'b0;
        @(negedge a_clk);
        @(negedge a_clk); #1;
        check_output("ra_access_penable", 32'(p_enable), 32'd1);
        a_reset_n = 1'b0;
        #1;
        check_output("ra_async_psel", 32'(p_sel), 32'd0);
        check_output("ra_async_penable", 32'(p_enable), 32'd0);
        check_output("ra_async_done", 32'(done), 32'd0);
        @(negedge a_clk); #1;
        check_output("ra_held_psel", 32'(p_sel), 32'd0);
        check_output("ra_held_done", 32'(done), 32'd0);
        req_valid = 2'b11;
        p_ready   = 1'b1;
        a_reset_n = 1'b1;
        @(negedge a_clk); #1;
        check_output("ra_first_grant_addr", p_addr, 32'h0000_0500);
        @(negedge a_clk); #1;
        check_output("ra_first_done", 32'(done), 32'd1);
        req_valid = 2'b00;
        @(negedge a_clk); #1;
        check_output("ra_idle_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_port_arbiter.md
APB_PORT_ARBITER -- requirements
Module: apb_port_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 2, number of request ports (legal 2..4).
REQ-002 SHALL have parameter TimeoutCycles, default 16, p_clk_en-qualified ACCESS cycles before forced error (0 = timeout disabled).
REQ-003 SHALL have port a_clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port a_reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  in  NumPorts  per-port transfer request, held until that port's done pulse.
REQ-006 SHALL have port req_addr  in  NumPorts x 32  per-port address, stable while req_valid.
REQ-007 SHALL have port req_write  in  NumPorts  per-port direction, 1 = write, stable while req_valid.
REQ-008 SHALL have port req_wdata  in  NumPorts x 32  per-port write data, stable while req_valid.
REQ-009 SHALL have port done  out  NumPorts  one-cycle completion pulse to the granted port.
REQ-010 SHALL have port rsp_rdata  out  32  read data, valid during done.
REQ-011 SHALL have port rsp_slverr  out  1  error flag, valid during done.
REQ-012 SHALL have ports p_clk_en in 1, p_addr out 32, p_sel out 1, p_enable out 1, p_write out 1, p_wdata out 32, p_rdata in 32, p_ready in 1, p_slverr in 1 (APB master).

Function
REQ-013 SHALL run a state machine IDLE/SETUP/ACCESS in which every transition occurs only on a_clk edges where p_clk_en=1.
REQ-014 SHALL, in IDLE with p_clk_en=1 and any req_valid set, register the arbitration winner in grant and move to SETUP.
REQ-015 SHALL arbitrate round-robin: priority starts at last_grant+1 modulo NumPorts; last_grant updates on each grant.
REQ-016 SHALL drive p_sel=1, p_enable=0 in SETUP, and move to ACCESS on the next p_clk_en=1 cycle.
REQ-017 SHALL drive p_sel=1, p_enable=1 in ACCESS.
REQ-018 SHALL drive p_sel=0, p_enable=0 in IDLE.
REQ-019 SHALL mux p_addr, p_write and p_wdata combinationally from the port indexed by grant, in all states.
REQ-020 SHALL, in ACCESS with p_clk_en=1 and p_ready=1, assert done[grant] for that same cycle and return to IDLE.
REQ-021 SHALL drive rsp_rdata=p_rdata and rsp_slverr=p_slverr during the REQ-020 pulse.
REQ-022 SHALL count p_clk_en=1 ACCESS cycles with p_ready=0.
REQ-023 SHALL, when that count reaches TimeoutCycles (nonzero), assert done[grant] with rsp_slverr=1 and rsp_rdata=0, and return to IDLE.
REQ-024 SHALL clear the timeout counter on entry to ACCESS.
REQ-025 SHALL give p_ready=1 priority over timeout on the same cycle (normal completion).
REQ-026 SHALL have at most one done bit set at any time; done SHALL be 0 outside REQ-020/REQ-023 cycles.
REQ-027 SHALL always return to IDLE after completion; back-to-back grants therefore have a minimum of one IDLE p_clk_en cycle between transfers.
REQ-028 SHALL ignore req_valid deassertion by the granted port mid-transfer; the transfer completes and done still pulses.
REQ-029 SHALL hold all state while p_clk_en=0, with outputs stable.
REQ-030 SHALL drive rsp_rdata=0 and rsp_slverr=0 when no done bit is set.

Reset
REQ-031 SHALL, on a_reset_n=0 and immediately (asynchronously), set state=IDLE, grant=0, last_grant=NumPorts-1 and timeout count=0.
REQ-032 SHALL, during reset, drive p_sel=0, p_enable=0 and done=0.
REQ-033 SHALL abandon an in-flight transfer on reset with no done pulse; the first post-reset grant goes to port 0 if requesting.

Verification
REQ-034 SHALL verify single read: p_clk_en=1, port0 read addr 0x100, p_ready=1 in ACCESS, p_rdata=0xDEADBEEF -> SETUP one cycle, ACCESS one cycle, done[0] with rsp_rdata=0xDEADBEEF, rsp_slverr=0.
REQ-035 SHALL verify fairness: ports 0 and 1 both request continuously for 4 transfers -> grant order 0,1,0,1.
REQ-036 SHALL verify clock enable: p_clk_en=1 every third cycle, single write 0x5A5A5A5A to 0x20 -> phases advance only on enabled edges, p_wdata=0x5A5A5A5A, p_write=1, done after 3 enabled edges.
REQ-037 SHALL verify timeout: TimeoutCycles=4 and p_ready held 0 -> done after 4 enabled ACCESS cycles with rsp_slverr=1, rsp_rdata=0; next grant proceeds.
REQ-038 SHALL verify slave error: p_slverr=1 with p_ready=1 -> done with rsp_slverr=1.
REQ-039 SHALL verify reset in ACCESS: a_reset_n low mid-ACCESS -> p_sel=0 immediately, no done; after release, port 0 is granted first.
